// File: rtl/psu_vector_gen.sv
// Stimulus source for the PSU code-word checker: bursts of LFSR words followed by two directed match words.
// Optional feature: define PSU_GEN_LOOP_EN to repeat bursts back-to-back until reset.
module psu_vector_gen #(
   parameter int                WIDTH      = 19,
   parameter int                NUM_RANDOM = 10,
   parameter logic [WIDTH-1:0]  SEED       = 19'h00001,
   parameter logic [WIDTH-1:0]  PAT0       = 19'b0000001010101111100,
   parameter logic [WIDTH-1:0]  PAT1       = 19'b0010010011011101000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [WIDTH-1:0] M,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             match_exp,
   output logic             busy,
   output logic             done,
   output logic [10:0]      vec_count
);

   typedef enum logic [2:0] {
      IDLE,
      RAND,
      DIR0,
      DIR1,
      DONE
   } state_t;

   localparam logic [9:0]  RAND_LAST = 10'(NUM_RANDOM - 1);
   localparam logic [10:0] COUNT_MAX = 11'h7FF;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] lfsr;
   logic [WIDTH-1:0] lfsr_next;
   logic [9:0]       rand_cnt;
   logic [9:0]       rand_cnt_next;
   logic [10:0]      vec_count_next;
   logic             accept;
   logic             feedback;

   // Polynomial x^19+x^18+x^17+x^14+1, shifting toward the MSB.
   assign feedback = lfsr[18] ^ lfsr[17] ^ lfsr[16] ^ lfsr[13];
   assign accept   = m_valid && m_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         lfsr      <= SEED;
         rand_cnt  <= '0;
         vec_count <= '0;
      end else begin
         state     <= state_next;
         lfsr      <= lfsr_next;
         rand_cnt  <= rand_cnt_next;
         vec_count <= vec_count_next;
      end
   end

   always_comb begin
      state_next     = state;
      lfsr_next      = lfsr;
      rand_cnt_next  = rand_cnt;
      vec_count_next = vec_count;

      if (accept && (vec_count != COUNT_MAX)) begin
         vec_count_next = vec_count + 11'd1;
      end

      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_next     = RAND;
               lfsr_next      = SEED;
               rand_cnt_next  = '0;
               vec_count_next = '0;
            end
         end
         RAND: begin
            if (accept) begin
               lfsr_next = {lfsr[WIDTH-2:0], feedback};
               if (rand_cnt == RAND_LAST) begin
                  state_next    = DIR0;
                  rand_cnt_next = '0;
               end else begin
                  rand_cnt_next = rand_cnt + 10'd1;
               end
            end
         end
         DIR0: begin
            if (accept) begin
               state_next = DIR1;
            end
         end
         DIR1: begin
            if (accept) begin
`ifdef PSU_GEN_LOOP_EN
               // The LFSR keeps running so each loop continues the sequence.
               state_next     = RAND;
               rand_cnt_next  = '0;
               vec_count_next = '0;
`else
               state_next = DONE;
`endif
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_comb begin
      M         = '0;
      m_valid   = 1'b0;
      match_exp = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;

      case (state)
         RAND: begin
            M       = lfsr;
            m_valid = 1'b1;
            busy    = 1'b1;
         end
         DIR0: begin
            M         = PAT0;
            m_valid   = 1'b1;
            match_exp = 1'b1;
            busy      = 1'b1;
         end
         DIR1: begin
            M         = PAT1;
            m_valid   = 1'b1;
            match_exp = 1'b1;
            busy      = 1'b1;
         end
         DONE: begin
            done = 1'b1;
         end
         default: begin
            M = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_psu_vector_gen.sv
// Scoreboard bench for psu_vector_gen: expected words are queued at stimulus time and popped by monitors.
// A second instance with a sparse seed exercises each LFSR tap individually.
module tb_psu_vector_gen;

   localparam int               WIDTH    = 19;
   localparam logic [WIDTH-1:0] SEED     = 19'h00001;
   localparam logic [WIDTH-1:0] TAP_SEED = 19'h02000;
   localparam logic [WIDTH-1:0] PAT0     = 19'b0000001010101111100;
   localparam logic [WIDTH-1:0] PAT1     = 19'b0010010011011101000;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             m_ready;
   logic [WIDTH-1:0] M;
   logic             m_valid;
   logic             match_exp;
   logic             busy;
   logic             done;
   logic [10:0]      vec_count;

   logic             startTap;
   logic             readyTap;
   logic [WIDTH-1:0] tapM;
   logic             tapValid;
   logic             tapMatch;
   logic             tapBusy;
   logic             tapDone;
   logic [10:0]      tapCount;

   int checks = 0;
   int errors = 0;
   int cycleCount = 0;
   int acceptCount = 0;
   int tapAccepts = 0;
   int lastAcceptCycle = 0;

   logic [WIDTH:0] expQ[$];
   logic [WIDTH:0] tapQ[$];
   logic           holdPending = 1'b0;
   logic [WIDTH:0] heldWord;

   logic [WIDTH-1:0] seedWords[10] = '{19'h00001, 19'h00002, 19'h00004, 19'h00008, 19'h00010,
                                       19'h00020, 19'h00040, 19'h00080, 19'h00100, 19'h00200};
   logic [WIDTH-1:0] tapWords[10]  = '{19'h02000, 19'h04001, 19'h08002, 19'h10004, 19'h20009,
                                       19'h40013, 19'h00027, 19'h0004E, 19'h0009C, 19'h00138};
   logic             readyPattern[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   psu_vector_gen #(.SEED(SEED)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .M         (M),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .match_exp (match_exp),
      .busy      (busy),
      .done      (done),
      .vec_count (vec_count)
   );

   psu_vector_gen #(.SEED(TAP_SEED)) u_dut_tap (
      .clk       (clk),
      .rst       (rst),
      .start     (startTap),
      .M         (tapM),
      .m_valid   (tapValid),
      .m_ready   (readyTap),
      .match_exp (tapMatch),
      .busy      (tapBusy),
      .done      (tapDone),
      .vec_count (tapCount)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleCount <= cycleCount + 1;

   // Pops on every transfer and checks that a stalled word stays put.
   always @(negedge clk) begin
      logic [WIDTH:0] e;
      if (rst) begin
         holdPending = 1'b0;
      end else begin
         if (holdPending) begin
            checks++;
            if (!m_valid || ({match_exp, M} !== heldWord)) begin
               errors++;
               $display("[TB] FAIL hold: got valid=%0b match=%0b M=%h, required valid=1 match=%0b M=%h",
                        m_valid, match_exp, M, heldWord[WIDTH], heldWord[WIDTH-1:0]);
            end
         end
         holdPending = 1'b0;
         if (m_valid && m_ready) begin
            checks++;
            if (expQ.size() == 0) begin
               errors++;
               $display("[TB] FAIL word: got match=%0b M=%h, required no word", match_exp, M);
            end else begin
               e = expQ.pop_front();
               if ({match_exp, M} !== e) begin
                  errors++;
                  $display("[TB] FAIL word: got match=%0b M=%h, required match=%0b M=%h",
                           match_exp, M, e[WIDTH], e[WIDTH-1:0]);
               end
            end
            acceptCount++;
            lastAcceptCycle = cycleCount + 1;
         end else if (m_valid) begin
            holdPending = 1'b1;
            heldWord    = {match_exp, M};
         end
      end
   end

   always @(negedge clk) begin
      logic [WIDTH:0] e;
      if (!rst && tapValid && readyTap) begin
         checks++;
         if (tapQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL tapWord: got match=%0b M=%h, required no word", tapMatch, tapM);
         end else begin
            e = tapQ.pop_front();
            if ({tapMatch, tapM} !== e) begin
               errors++;
               $display("[TB] FAIL tapWord: got match=%0b M=%h, required match=%0b M=%h",
                        tapMatch, tapM, e[WIDTH], e[WIDTH-1:0]);
            end
         end
         tapAccepts++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic r, input logic rdy);
      start   = s;
      rst     = r;
      m_ready = rdy;
      tick();
   endtask

   task automatic pushBurst(input int n);
      for (int i = 0; i < 10 && i < n; i++) expQ.push_back({1'b0, seedWords[i]});
      if (n > 10) expQ.push_back({1'b1, PAT0});
      if (n > 11) expQ.push_back({1'b1, PAT1});
   endtask

   task automatic waitDone(input int maxCycles);
      int i;
      for (i = 0; i < maxCycles; i++) begin
         if (done) break;
         tick();
      end
      checks++;
      if (!done) begin
         errors++;
         $display("[TB] FAIL doneTimeout: got done=0 after %0d cycles, required done=1", maxCycles);
      end
   endtask

   task automatic waitAccepts(input bit tapPort, input int target, input int maxCycles);
      int i;
      for (i = 0; i < maxCycles; i++) begin
         tick();
         if ((tapPort ? tapAccepts : acceptCount) >= target) break;
      end
      checks++;
      if ((tapPort ? tapAccepts : acceptCount) < target) begin
         errors++;
         $display("[TB] FAIL acceptTimeout: got %0d accepts, required %0d",
                  tapPort ? tapAccepts : acceptCount, target);
      end
   endtask

   initial begin
      int startCycle;
      int base;

      startTap = 1'b0;
      readyTap = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);

      $display("[TB] reset defaults");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b0, i[0]);
         checkOutput("rstValid", 32'(m_valid), 32'd0);
         checkOutput("rstM", 32'(M), 32'd0);
         checkOutput("rstMatch", 32'(match_exp), 32'd0);
         checkOutput("rstBusy", 32'(busy), 32'd0);
         checkOutput("rstDone", 32'(done), 32'd0);
         checkOutput("rstCount", 32'(vec_count), 32'd0);
      end

      $display("[TB] tap coverage burst");
      for (int i = 0; i < 10; i++) tapQ.push_back({1'b0, tapWords[i]});
      tapQ.push_back({1'b1, PAT0});
      tapQ.push_back({1'b1, PAT1});
      startTap = 1'b1;
      readyTap = 1'b1;
      tick();
      startTap = 1'b0;
      waitAccepts(1'b1, 12, 40);
      readyTap = 1'b0;
      checkOutput("tapQueue", 32'(tapQ.size()), 32'd0);

`ifdef PSU_GEN_LOOP_EN
      $display("[TB] loop mode");
      pushBurst(12);
      expQ.push_back({1'b0, 19'h00400});
      expQ.push_back({1'b0, 19'h00800});
      base = acceptCount;
      applyStimulus(1'b1, 1'b0, 1'b1);
      start = 1'b0;
      waitAccepts(1'b0, base + 14, 60);
      m_ready = 1'b0;
      checkOutput("loopDone", 32'(done), 32'd0);
      checkOutput("loopBusy", 32'(busy), 32'd1);
      checkOutput("loopCount", 32'(vec_count), 32'd2);
      checkOutput("loopM", 32'(M), 32'h01000);
      checkOutput("loopQueue", 32'(expQ.size()), 32'd0);
      repeat (3) tick();
      checkOutput("loopDoneLater", 32'(done), 32'd0);
`else
      $display("[TB] full burst");
      pushBurst(12);
      applyStimulus(1'b1, 1'b0, 1'b1);
      startCycle = cycleCount;
      start = 1'b0;
      checkOutput("startValid", 32'(m_valid), 32'd1);
      checkOutput("startM", 32'(M), 32'(SEED));
      checkOutput("startBusy", 32'(busy), 32'd1);
      waitDone(50);
      checkOutput("throughput", 32'(cycleCount - startCycle), 32'd12);
      checkOutput("doneTiming", 32'(cycleCount), 32'(lastAcceptCycle));
      checkOutput("burstCount", 32'(vec_count), 32'd12);
      checkOutput("doneValid", 32'(m_valid), 32'd0);
      checkOutput("doneBusy", 32'(busy), 32'd0);
      checkOutput("burstQueue", 32'(expQ.size()), 32'd0);
      repeat (3) tick();
      checkOutput("doneSticky", 32'(done), 32'd1);

      $display("[TB] restart with backpressure and ignored start");
      pushBurst(12);
      applyStimulus(1'b1, 1'b0, 1'b1);
      start = 1'b0;
      checkOutput("restartDone", 32'(done), 32'd0);
      checkOutput("restartM", 32'(M), 32'(SEED));
      for (int i = 0; i < 200; i++) begin
         if (done) break;
         applyStimulus(i == 5, 1'b0, readyPattern[i % 4]);
      end
      start = 1'b0;
      checkOutput("bpDone", 32'(done), 32'd1);
      checkOutput("bpCount", 32'(vec_count), 32'd12);
      checkOutput("bpQueue", 32'(expQ.size()), 32'd0);

      $display("[TB] reset mid-burst");
      pushBurst(4);
      base = acceptCount;
      applyStimulus(1'b1, 1'b0, 1'b1);
      start = 1'b0;
      waitAccepts(1'b0, base + 4, 20);
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput("midRstValid", 32'(m_valid), 32'd0);
      checkOutput("midRstCount", 32'(vec_count), 32'd0);
      checkOutput("midRstBusy", 32'(busy), 32'd0);
      checkOutput("midRstQueue", 32'(expQ.size()), 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("startWithReset", 32'(m_valid), 32'd0);

      pushBurst(12);
      applyStimulus(1'b1, 1'b0, 1'b1);
      start = 1'b0;
      checkOutput("replayM", 32'(M), 32'(SEED));
      waitDone(50);
      checkOutput("replayCount", 32'(vec_count), 32'd12);
      checkOutput("replayQueue", 32'(expQ.size()), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/psu_vector_gen.md
# psu_vector_gen

Sequential stimulus source for the PSU code-word checker: emits a fixed-length burst of 19-bit code words on a valid/ready interface. Each burst is NUM_RANDOM pseudo-random words from a maximal-length 19-bit LFSR, followed by two directed words that the checker must flag as matches. Every word carries a tag saying whether a match is expected, so a scoreboard can compare it against the checker's `Result`.

## Interface
- `WIDTH`, 19 — code-word width; the LFSR taps below are fixed for 19.
- `NUM_RANDOM`, 10 — random words per burst, 1..1023.
- `SEED`, 19'h00001 — LFSR load value; must be non-zero.
- `PAT0`, 19'b0000001010101111100 — first directed word.
- `PAT1`, 19'b0010010011011101000 — second directed word.

- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `start` in 1 — one-cycle request to begin a burst.
- `M` out WIDTH — code word toward the checker.
- `m_valid` out 1 — `M` is valid.
- `m_ready` in 1 — consumer accepts `M`.
- `match_exp` out 1 — 1 when `M` is `PAT0` or `PAT1`; qualified by `m_valid`.
- `busy` out 1 — burst in progress.
- `done` out 1 — burst complete; sticky.
- `vec_count` out 11 — words accepted in the current burst.

## Operation
- **States:** IDLE, RAND, DIR0, DIR1, DONE.
- **Handshake:** a word transfers on a cycle with `m_valid && m_ready`.
  - While `m_valid=1`, `M` and `match_exp` stay stable until accepted.
  - `m_valid` never drops without an accept.
- **IDLE:**
  - `start=1` reloads the LFSR with `SEED`, clears `vec_count`, goes to RAND.
  - `start` is ignored in RAND, DIR0 and DIR1.
- **RAND:**
  - `M` = current LFSR value, `match_exp=0`.
  - On accept, the LFSR steps: next = {lfsr[17:0], lfsr[18]^lfsr[17]^lfsr[16]^lfsr[13]} (x^19+x^18+x^17+x^14+1).
  - After NUM_RANDOM accepts, go to DIR0.
- **DIR0:** `M=PAT0`, `match_exp=1`; on accept go to DIR1.
- **DIR1:** `M=PAT1`, `match_exp=1`; on accept go to DONE.
- **DONE:**
  - `done=1`, `m_valid=0`, `busy=0`.
  - `start=1` clears `done`, reloads `SEED`, clears `vec_count`, enters RAND.
- **Counter:** `vec_count` increments on every accept and saturates at 2047. After a full burst it reads NUM_RANDOM+2.
- **LFSR stepping:** the LFSR steps only on RAND accepts. It never steps in DIR0, DIR1, IDLE or DONE.
- **`busy`:** 1 in RAND, DIR0 and DIR1 only.

## Timing
- **Reset values:** state=IDLE, LFSR=SEED, `M`=0, `m_valid`=0, `match_exp`=0, `busy`=0, `done`=0, `vec_count`=0.
- **Start latency:** `start` sampled in cycle N gives `m_valid=1` with `M=SEED` in cycle N+1.
- **Throughput:** one word per cycle. With `m_ready` held high, the next word appears in the cycle after each accept, with no bubbles, including across RAND→DIR0→DIR1.
- **Backpressure:** `m_ready=0` holds all outputs and internal state frozen, for any number of cycles.
- **DONE entry:** `done` rises in the cycle after the PAT1 accept, and `m_valid` falls in the same cycle.
- **`start` with reset:** `start` and `rst` high in the same cycle resolve to reset only.
- **Reset mid-burst:** returns to IDLE next cycle. No word is emitted, and a pending unaccepted word is dropped.
- **`m_ready` while idle:** `m_ready` is ignored when `m_valid=0`.

## Configuration
- **`PSU_GEN_LOOP_EN` defined:**
  - After the PAT1 accept, the FSM goes straight to RAND instead of DONE.
  - The LFSR is not reloaded; the sequence continues.
  - `vec_count` clears to 0 on re-entry.
  - Bursts repeat until `rst`; `done` stays 0 and `busy` stays 1 after the first `start`.
- **Not defined:** behaviour is as described under Operation; a single burst per `start`.

## Test plan
- **Reset defaults:** hold `rst` 3 cycles, then release with `start` low → all outputs at reset values for 5 cycles; `m_valid` stays 0.
- **Full burst:** `SEED`=19'h00001, `start` pulse, `m_ready`=1 →
  - `M` sequence 19'h00001, 19'h00002, 19'h00004, … (10 words), then `PAT0`, then `PAT1`.
  - `match_exp` is 1 only on the last two words.
  - `done` rises one cycle after the `PAT1` accept; `vec_count`=12.
- **Backpressure:** `m_ready` toggled 1,0,0,1,… → `M` holds its value across the low cycles; no words are skipped or repeated; the same 12-word sequence results.
- **Reset mid-burst:** `rst` asserted after the 4th accept → next cycle `m_valid`=0, `vec_count`=0, state IDLE. A new `start` replays from 19'h00001.
- **Restart and ignored start:**
  - `start` during RAND → no effect.
  - `start` in DONE → `done` clears and a new burst begins with `M`=`SEED`.
- **Loop mode (`PSU_GEN_LOOP_EN`):** after `PAT1`, the 13th word equals the LFSR value following the 10th random word (not `SEED`); `done` is never asserted.
